hwpe_stream_source_realign_desc: RTL and testbench
==================================================

Name: hwpe_stream_source_realign_desc

Overview:
Byte-granular realigner for TCDM-sourced load streams. Each line is described by an explicit descriptor (byte offset, byte length) held in a small descriptor FIFO, so address generation is fully decoupled from data arrival. Misaligned input words are stitched into aligned output words, and a residual flush beat is emitted when needed. The final output beat of each line carries a correct partial strobe. Sits between the TCDM load path (after any load FIFO) and the datapath's stream input.

Parameters:
DATA_WIDTH, 32, stream data width in bits; multiple of 8, BW = DATA_WIDTH/8 bytes.
LEN_WIDTH, 16, width of the line byte-length field.
DESC_FIFO_DEPTH, 4, descriptor FIFO entries; power of 2, >= 2.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
clear_i  in  1  synchronous soft clear
desc_valid_i  in  1  descriptor push request
desc_ready_o  out  1  descriptor FIFO not full
desc_offset_i  in  $clog2(BW)  byte offset of line start within first input word
desc_len_i  in  LEN_WIDTH  line length in bytes
stream_i  hwpe_stream_intf_stream.sink  DATA_WIDTH  misaligned word stream from TCDM
stream_o  hwpe_stream_intf_stream.source  DATA_WIDTH  aligned output stream
busy_o  out  1  FSM not IDLE or FIFO non-empty
desc_count_o  out  $clog2(DESC_FIFO_DEPTH)+1  descriptor FIFO occupancy

Behaviour:
- Reset/clear: FSM=IDLE; FIFO empty; prev_q=0; counters=0; stream_o.valid=0; stream_i.ready=0; desc_ready_o=1; busy_o=0. Clear has priority over every other event. A push in the same cycle as clear is dropped.
- Per line: N_in = ceil((off+len)/BW), N_out = ceil(len/BW). Both are computed on pop at LEN_WIDTH+1 bits. N_in is either N_out or N_out+1.
- Stitch: out = (prev_q >> 8*off) | (cur << 8*(BW-off)), computed on register-free combinational path.
- prev_q <= stream_i.data on every input handshake.
- FSM:
  - IDLE: if FIFO non-empty, pop the head into working registers.
    - len==0: pop and discard, stay in IDLE.
    - off==0: go to PASS.
    - otherwise: go to PRIME.
  - PASS: stream_o mirrors stream_i, zero latency; stream_i.ready=stream_o.ready. Count N_out beats, then go to IDLE.
  - PRIME: stream_i.ready=1, stream_o.valid=0. On the first handshake go to STREAM.
  - STREAM: stream_o.valid=stream_i.valid, data=stitch, stream_i.ready=stream_o.ready.
    - After N_in-1 input beats: go to FLUSH if N_in==N_out, otherwise go to IDLE.
  - FLUSH: stream_o.valid=1, data=prev_q>>8*off, stream_i.ready=0. On handshake go to IDLE.
- Strobe:
  - stream_o.strb='1 on every beat except the line's last output beat.
  - Last output beat: lower (len mod BW) bytes set, or all bytes set if (len mod BW)==0.
  - stream_i.strb is ignored.
- Handshake: stream_o.valid never depends on stream_o.ready. Data and strb are held stable while valid && !ready.
- Descriptor FIFO: push and pop in the same cycle when full is allowed, because pop frees the slot; desc_ready_o is combinational from count and pop. Push when full is ignored.
- IDLE→next line costs one cycle (pop cycle). No back-to-back line overlap.
- Reset or clear mid-line: the partial line is abandoned; no flush beat is emitted.

Decomposition:
- hwpe_stream_package gains:
  - typedef realign_desc_t {offset, len}
  - enum realign_state_t {IDLE, PASS, PRIME, STREAM, FLUSH}
- Sub-module hwpe_stream_realign_desc_fifo: parametrised register FIFO of realign_desc_t with count output and async active-high reset.
- Beat counters and the stitch shifter stay in the top module.

Test Plan:
- DATA_WIDTH=32, desc off=0 len=8; in 0x03020100,0x07060504 -> out the same 2 words, strb 0xF,0xF, zero latency, back to IDLE.
- off=1 len=8; in 0x03020100,0x07060504,0x0B0A0908 -> first word absorbed; out 0x04030201 strb 0xF, then 0x08070605 strb 0xF; no flush.
- off=2 len=6; in 0x03020100,0x07060504 -> out 0x05040302 strb 0xF, then FLUSH 0x00000706 strb 0x3 with stream_i.ready=0.
- off=3 len=5; hold stream_o.ready=0 for 3 cycles mid-line -> out data and strb stable; no input consumed. Final out 0x00000007-aligned residual carries strb 0x1.
- Push 5 descriptors (depth 4) while streaming is stalled -> desc_ready_o=0 after 4, desc_count_o=4. Fifth push is ignored; lines then complete in order. A len=0 descriptor is popped with no output beat.
- Assert clear_i during STREAM, then separately assert rst_i mid-line -> next cycle IDLE, desc_count_o=0, stream_o.valid=0. A new descriptor then realigns correctly with prev_q state discarded.

Source files
------------

// File: rtl/hwpe_stream_package.sv
// Shared types for the descriptor-driven source realigner.
package hwpe_stream_package;

    localparam int unsigned REALIGN_DATA_WIDTH = 32;
    localparam int unsigned REALIGN_LEN_WIDTH  = 16;
    localparam int unsigned REALIGN_OFF_WIDTH  = $clog2(REALIGN_DATA_WIDTH / 8);

    typedef struct packed {
        logic [REALIGN_OFF_WIDTH-1:0] offset;
        logic [REALIGN_LEN_WIDTH-1:0] len;
    } realign_desc_t;

    typedef enum logic [2:0] {
        IDLE,
        PASS,
        PRIME,
        STREAM,
        FLUSH
    } realign_state_t;

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Valid/ready stream with byte strobes.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic                    valid;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;

    modport source (output valid, data, strb, input ready);
    modport sink   (input valid, data, strb, output ready);
endinterface

// File: rtl/hwpe_stream_realign_desc_fifo.sv
// Register FIFO of line descriptors; a pop frees its slot for a same-cycle push.
module hwpe_stream_realign_desc_fifo
    import hwpe_stream_package::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  realign_desc_t          data_i,
    output realign_desc_t          data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    realign_desc_t   mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) mem_q[wr_ptr_q] <= data_i;
    end
endmodule

// File: rtl/hwpe_stream_source_realign_desc.sv
// Realigns a misaligned TCDM load stream into aligned words, one descriptor per line.
module hwpe_stream_source_realign_desc
    import hwpe_stream_package::*;
#(
    parameter int unsigned DATA_WIDTH      = REALIGN_DATA_WIDTH,
    parameter int unsigned LEN_WIDTH       = REALIGN_LEN_WIDTH,
    parameter int unsigned DESC_FIFO_DEPTH = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             clear_i,
    input  logic                             desc_valid_i,
    output logic                             desc_ready_o,
    input  logic [$clog2(DATA_WIDTH/8)-1:0]  desc_offset_i,
    input  logic [LEN_WIDTH-1:0]             desc_len_i,
    hwpe_stream_intf_stream.sink             stream_i,
    hwpe_stream_intf_stream.source           stream_o,
    output logic                             busy_o,
    output logic [$clog2(DESC_FIFO_DEPTH):0] desc_count_o
);
    localparam int unsigned BW    = DATA_WIDTH / 8;
    localparam int unsigned OFF_W = $clog2(BW);
    localparam int unsigned CNT_W = LEN_WIDTH + 1;
    localparam int unsigned SH_W  = OFF_W + 4;
    localparam logic [BW-1:0] STRB_ALL = '1;

    realign_state_t        state_q, state_d;
    realign_desc_t         fifo_in, fifo_out;
    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [OFF_W-1:0]      h_off, off_q, rem_q;
    logic [LEN_WIDTH-1:0]  h_len;
    logic [CNT_W-1:0]      n_in_h, n_out_h, n_in_q, n_out_q, cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] prev_q, stitch, out_data;
    logic [SH_W-1:0]       sh_prev, sh_cur;
    logic [BW-1:0]         last_strb;
    logic                  in_ready, out_valid, last_beat, in_hs, unused_in_strb;

    assign unused_in_strb = ^stream_i.strb;

    assign fifo_in.offset = REALIGN_OFF_WIDTH'(desc_offset_i);
    assign fifo_in.len    = REALIGN_LEN_WIDTH'(desc_len_i);
    assign fifo_pop       = (state_q == IDLE) && !fifo_empty && !clear_i;
    assign desc_ready_o   = !fifo_full || fifo_pop;
    assign fifo_push      = desc_valid_i && desc_ready_o && !clear_i;

    hwpe_stream_realign_desc_fifo #(
        .DEPTH (DESC_FIFO_DEPTH)
    ) i_desc_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear_i),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .data_i  (fifo_in),
        .data_o  (fifo_out),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (desc_count_o)
    );

    assign h_off   = OFF_W'(fifo_out.offset);
    assign h_len   = LEN_WIDTH'(fifo_out.len);
    assign n_in_h  = (CNT_W'(h_off) + CNT_W'(h_len) + CNT_W'(BW - 1)) >> OFF_W;
    assign n_out_h = (CNT_W'(h_len) + CNT_W'(BW - 1)) >> OFF_W;

    // Previous word supplies the low bytes, current word the high bytes.
    assign sh_prev   = SH_W'({off_q, 3'b000});
    assign sh_cur    = SH_W'(DATA_WIDTH) - sh_prev;
    assign stitch    = (prev_q >> sh_prev) | (stream_i.data << sh_cur);
    assign last_strb = (rem_q == '0) ? STRB_ALL : ~(STRB_ALL << rem_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        last_beat = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && h_len != '0) begin
                    if (h_off == '0) begin
                        state_d = PASS;
                        cnt_d   = n_out_h;
                    end else begin
                        state_d = PRIME;
                    end
                end
            end
            PASS: begin
                out_valid = stream_i.valid;
                out_data  = stream_i.data;
                in_ready  = stream_o.ready;
                last_beat = (cnt_q == CNT_W'(1));
                if (stream_i.valid && stream_o.ready) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = IDLE;
                end
            end
            PRIME: begin
                in_ready = 1'b1;
                if (stream_i.valid) begin
                    cnt_d   = n_in_q - CNT_W'(1);
                    // A line fitting in one input word has nothing to stitch.
                    state_d = (n_in_q == CNT_W'(1)) ? FLUSH : STREAM;
                end
            end
            STREAM: begin
                out_valid = stream_i.valid;
                out_data  = stitch;
                in_ready  = stream_o.ready;
                last_beat = (cnt_q == CNT_W'(1)) && (n_in_q != n_out_q);
                if (stream_i.valid && stream_o.ready) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = (n_in_q == n_out_q) ? FLUSH : IDLE;
                end
            end
            FLUSH: begin
                out_valid = 1'b1;
                out_data  = prev_q >> sh_prev;
                last_beat = 1'b1;
                if (stream_o.ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign stream_o.valid = out_valid && !clear_i;
    assign stream_o.data  = out_data;
    assign stream_o.strb  = last_beat ? last_strb : STRB_ALL;
    assign stream_i.ready = in_ready && !clear_i;
    assign in_hs          = stream_i.valid && stream_i.ready;
    assign busy_o         = (state_q != IDLE) || !fifo_empty;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prev_q  <= '0;
            off_q   <= '0;
            rem_q   <= '0;
            n_in_q  <= '0;
            n_out_q <= '0;
        end else if (clear_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prev_q  <= '0;
            off_q   <= '0;
            rem_q   <= '0;
            n_in_q  <= '0;
            n_out_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (in_hs) prev_q <= stream_i.data;
            if (fifo_pop) begin
                off_q   <= h_off;
                rem_q   <= OFF_W'(h_len);
                n_in_q  <= n_in_h;
                n_out_q <= n_out_h;
            end
        end
    end
endmodule

// File: tb/tb_hwpe_stream_source_realign_desc.sv
// Directed bench: a per-cycle vector table plus clear/reset abort sequences.
module tb_hwpe_stream_source_realign_desc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clear, desc_valid, desc_ready, busy;
    logic [1:0]  desc_offset;
    logic [15:0] desc_len;
    logic [2:0]  desc_count;

    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) s_in ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) s_out ();

    hwpe_stream_source_realign_desc #(
        .DATA_WIDTH(32), .LEN_WIDTH(16), .DESC_FIFO_DEPTH(4)
    ) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear),
        .desc_valid_i(desc_valid), .desc_ready_o(desc_ready),
        .desc_offset_i(desc_offset), .desc_len_i(desc_len),
        .stream_i(s_in), .stream_o(s_out),
        .busy_o(busy), .desc_count_o(desc_count)
    );

    typedef struct {
        logic        dv;
        logic [1:0]  doff;
        logic [15:0] dlen;
        logic        iv;
        logic [31:0] idata;
        logic        ordy;
        logic        ov;
        logic [31:0] od;
        logic [3:0]  os;
        logic        ir;
        logic        drdy;
        logic [2:0]  cnt;
    } vec_t;

    vec_t vq[$];
    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(input logic dv, input logic [1:0] doff, input logic [15:0] dlen,
                                input logic iv, input logic [31:0] idata, input logic ordy,
                                input logic ov, input logic [31:0] od, input logic [3:0] os,
                                input logic ir, input logic drdy, input logic [2:0] cnt);
        vec_t v;
        v.dv = dv; v.doff = doff; v.dlen = dlen; v.iv = iv; v.idata = idata; v.ordy = ordy;
        v.ov = ov; v.od = od; v.os = os; v.ir = ir; v.drdy = drdy; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic dv, input logic [1:0] doff, input logic [15:0] dlen,
                          input logic iv, input logic [31:0] idata, input logic ordy);
        desc_valid  = dv;
        desc_offset = doff;
        desc_len    = dlen;
        s_in.valid  = iv;
        s_in.data   = idata;
        s_in.strb   = 4'hF;
        s_out.ready = ordy;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        // off=0 len=8: zero-latency pass-through
        vq.push_back(mk(1,0,8,  0,32'h0,1,        0,32'h0,4'h0,        0,1,0));
        vq.push_back(mk(0,0,0,  0,32'h0,1,        0,32'h0,4'h0,        0,1,1));
        vq.push_back(mk(0,0,0,  1,32'h03020100,1, 1,32'h03020100,4'hF, 1,1,0));
        vq.push_back(mk(0,0,0,  1,32'h07060504,1, 1,32'h07060504,4'hF, 1,1,0));
        vq.push_back(mk(0,0,0,  0,32'h0,1,        0,32'h0,4'h0,        0,1,0));
        // off=1 len=8: three inputs, two outputs, no flush
        vq.push_back(mk(1,1,8,  0,32'h0,1,        0,32'h0,4'h0,        0,1,0));
        vq.push_back(mk(0,0,0,  0,32'h0,1,        0,32'h0,4'h0,        0,1,1));
        vq.push_back(mk(0,0,0,  1,32'h03020100,1, 0,32'h0,4'h0,        1,1,0));
        vq.push_back(mk(0,0,0,  1,32'h07060504,1, 1,32'h04030201,4'hF, 1,1,0));
        vq.push_back(mk(0,0,0,  1,32'h0B0A0908,1, 1,32'h08070605,4'hF, 1,1,0));
        vq.push_back(mk(0,0,0,  1,32'hCAFEF00D,1, 0,32'h0,4'h0,        0,1,0));
        // off=2 len=6: flush beat with partial strobe
        vq.push_back(mk(1,2,6,  0,32'h0,1,        0,32'h0,4'h0,        0,1,0));
        vq.push_back(mk(0,0,0,  0,32'h0,1,        0,32'h0,4'h0,        0,1,1));
        vq.push_back(mk(0,0,0,  1,32'h03020100,1, 0,32'h0,4'h0,        1,1,0));
        vq.push_back(mk(0,0,0,  1,32'h07060504,1, 1,32'h05040302,4'hF, 1,1,0));
        vq.push_back(mk(0,0,0,  1,32'hDEADBEEF,1, 1,32'h00000706,4'h3, 0,1,0));
        vq.push_back(mk(0,0,0,  0,32'h0,1,        0,32'h0,4'h0,        0,1,0));
        // off=3 len=5: output stall mid-line
        vq.push_back(mk(1,3,5,  0,32'h0,1,        0,32'h0,4'h0,        0,1,0));
        vq.push_back(mk(0,0,0,  0,32'h0,1,        0,32'h0,4'h0,        0,1,1));
        vq.push_back(mk(0,0,0,  1,32'h03020100,0, 0,32'h0,4'h0,        1,1,0));
        vq.push_back(mk(0,0,0,  1,32'h07060504,0, 1,32'h06050403,4'hF, 0,1,0));
        vq.push_back(mk(0,0,0,  1,32'h07060504,0, 1,32'h06050403,4'hF, 0,1,0));
        vq.push_back(mk(0,0,0,  1,32'h07060504,0, 1,32'h06050403,4'hF, 0,1,0));
        vq.push_back(mk(0,0,0,  1,32'h07060504,1, 1,32'h06050403,4'hF, 1,1,0));
        vq.push_back(mk(0,0,0,  0,32'h0,0,        1,32'h00000007,4'h1, 0,1,0));
        vq.push_back(mk(0,0,0,  0,32'h0,1,        1,32'h00000007,4'h1, 0,1,0));
        vq.push_back(mk(0,0,0,  0,32'h0,1,        0,32'h0,4'h0,        0,1,0));
        // FIFO fill while a PASS line is stalled; fifth push ignored; len=0 skipped
        vq.push_back(mk(1,0,4,  0,32'h0,1,        0,32'h0,4'h0,        0,1,0));
        vq.push_back(mk(1,0,0,  0,32'h0,1,        0,32'h0,4'h0,        0,1,1));
        vq.push_back(mk(1,1,3,  0,32'h0,1,        0,32'h0,4'h0,        1,1,1));
        vq.push_back(mk(1,0,4,  0,32'h0,1,        0,32'h0,4'h0,        1,1,2));
        vq.push_back(mk(1,2,2,  0,32'h0,1,        0,32'h0,4'h0,        1,1,3));
        vq.push_back(mk(1,0,4,  0,32'h0,1,        0,32'h0,4'h0,        1,0,4));
        vq.push_back(mk(0,0,0,  1,32'h11223344,1, 1,32'h11223344,4'hF, 1,0,4));
        vq.push_back(mk(0,0,0,  0,32'h0,1,        0,32'h0,4'h0,        0,1,4));
        vq.push_back(mk(0,0,0,  0,32'h0,1,        0,32'h0,4'h0,        0,1,3));
        vq.push_back(mk(0,0,0,  1,32'hA3A2A1A0,1, 0,32'h0,4'h0,        1,1,2));
        vq.push_back(mk(0,0,0,  0,32'h0,1,        1,32'h00A3A2A1,4'h7, 0,1,2));
        vq.push_back(mk(0,0,0,  0,32'h0,1,        0,32'h0,4'h0,        0,1,2));
        vq.push_back(mk(0,0,0,  1,32'hD3D2D1D0,1, 1,32'hD3D2D1D0,4'hF, 1,1,1));
        vq.push_back(mk(0,0,0,  0,32'h0,1,        0,32'h0,4'h0,        0,1,1));
        vq.push_back(mk(0,0,0,  1,32'hE3E2E1E0,1, 0,32'h0,4'h0,        1,1,0));
        vq.push_back(mk(0,0,0,  0,32'h0,1,        1,32'h0000E3E2,4'h3, 0,1,0));
        vq.push_back(mk(0,0,0,  0,32'h0,1,        0,32'h0,4'h0,        0,1,0));

        clear = 1'b0;
        rst   = 1'b0;
        set_in(0,0,0, 0,32'h0,1);
        #1 rst = 1'b1;
        #2;
        chk("rst ov",    32'(s_out.valid), 32'h0);
        chk("rst ir",    32'(s_in.ready),  32'h0);
        chk("rst drdy",  32'(desc_ready),  32'h1);
        chk("rst busy",  32'(busy),        32'h0);
        chk("rst count", 32'(desc_count),  32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            set_in(vq[i].dv, vq[i].doff, vq[i].dlen, vq[i].iv, vq[i].idata, vq[i].ordy);
            #4;
            chk($sformatf("v%0d ov", i),    32'(s_out.valid), 32'(vq[i].ov));
            chk($sformatf("v%0d ir", i),    32'(s_in.ready),  32'(vq[i].ir));
            chk($sformatf("v%0d drdy", i),  32'(desc_ready),  32'(vq[i].drdy));
            chk($sformatf("v%0d count", i), 32'(desc_count),  32'(vq[i].cnt));
            if (vq[i].ov) begin
                chk($sformatf("v%0d data", i), s_out.data,     vq[i].od);
                chk($sformatf("v%0d strb", i), 32'(s_out.strb), 32'(vq[i].os));
            end
            cyc();
        end
        chk("table idle busy", 32'(busy), 32'h0);

        // clear during STREAM, with a same-cycle push that must be dropped
        set_in(1,1,8, 0,32'h0,1);          cyc();
        set_in(0,0,0, 0,32'h0,1);          cyc();
        set_in(0,0,0, 1,32'h03020100,1);   cyc();
        set_in(0,0,0, 1,32'h07060504,1);   #4;
        chk("clr pre data", s_out.data, 32'h04030201);
        cyc();
        clear = 1'b1;
        set_in(1,0,4, 1,32'h0B0A0908,1);   #4;
        chk("clr cycle ov", 32'(s_out.valid), 32'h0);
        chk("clr cycle ir", 32'(s_in.ready),  32'h0);
        cyc();
        clear = 1'b0;
        set_in(0,0,0, 0,32'h0,1);          #4;
        chk("clr post ov",    32'(s_out.valid), 32'h0);
        chk("clr post count", 32'(desc_count),  32'h0);
        chk("clr post busy",  32'(busy),        32'h0);
        cyc();
        set_in(1,1,4, 0,32'h0,1);          cyc();
        set_in(0,0,0, 0,32'h0,1);          cyc();
        set_in(0,0,0, 1,32'h13121110,1);   #4;
        chk("clr new prime ir", 32'(s_in.ready),  32'h1);
        chk("clr new prime ov", 32'(s_out.valid), 32'h0);
        cyc();
        set_in(0,0,0, 1,32'h17161514,1);   #4;
        chk("clr new ov",   32'(s_out.valid), 32'h1);
        chk("clr new data", s_out.data,       32'h14131211);
        chk("clr new strb", 32'(s_out.strb),  32'hF);
        cyc();
        set_in(0,0,0, 0,32'h0,1);          #4;
        chk("clr new done", 32'(busy), 32'h0);
        cyc();

        // asynchronous reset while a flush beat is pending
        set_in(1,2,6, 0,32'h0,1);          cyc();
        set_in(0,0,0, 0,32'h0,1);          cyc();
        set_in(0,0,0, 1,32'h03020100,1);   cyc();
        set_in(0,0,0, 1,32'h07060504,1);   #4;
        chk("rstm stream data", s_out.data, 32'h05040302);
        cyc();
        set_in(0,0,0, 0,32'h0,0);          #2;
        chk("rstm flush pending", 32'(s_out.valid), 32'h1);
        rst = 1'b1;
        #1;
        chk("rstm ov",    32'(s_out.valid), 32'h0);
        chk("rstm ir",    32'(s_in.ready),  32'h0);
        chk("rstm count", 32'(desc_count),  32'h0);
        chk("rstm busy",  32'(busy),        32'h0);
        chk("rstm drdy",  32'(desc_ready),  32'h1);
        @(posedge clk);
        #1 rst = 1'b0;
        set_in(1,3,1, 0,32'h0,1);          cyc();
        set_in(0,0,0, 0,32'h0,1);          cyc();
        set_in(0,0,0, 1,32'h44332211,1);   #4;
        chk("rstm new prime ir", 32'(s_in.ready), 32'h1);
        cyc();
        set_in(0,0,0, 0,32'h0,1);          #4;
        chk("rstm new ov",   32'(s_out.valid), 32'h1);
        chk("rstm new data", s_out.data,       32'h00000044);
        chk("rstm new strb", 32'(s_out.strb),  32'h1);
        chk("rstm new ir",   32'(s_in.ready),  32'h0);
        cyc();
        #4;
        chk("rstm new done", 32'(busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
